// File: rtl/exc_pkg.sv
// Shared definitions for the WB exception/ERTN commit sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: LoongArch exception codes, sequencer state and commit-kind enums,
// and a helper that flags the codes which also write BADV.
package exc_pkg;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0b;
  localparam logic [5:0] ECODE_BRK  = 6'h0c;
  localparam logic [5:0] ECODE_INE  = 6'h0d;

  typedef enum logic [1:0] {IDLE, COMMIT, REDIR, HOLD} state_t;

  typedef enum logic {EXC, ERTN} kind_t;

  // Address faults are the only exceptions that also record a bad address.
  function automatic logic ecode_sets_badv(input logic [5:0] ecode);
    return (ecode == ECODE_ADEF) || (ecode == ECODE_ALE);
  endfunction

endpackage

// File: rtl/wb_exc_ctrl.sv
// Exception/ERTN commit sequencer: captures one WB commit, pulses CSR writes, flushes, redirects IF.
// Latency: accept -> CSR pulse 1 cycle, accept -> redir_valid 2 cycles, busy >= 3+FLUSH_HOLD cycles.
// Backpressure: submit_ready low while busy (late submits ignored); redirect waits on redir_ready.
// Ports: clk/resetn (sync, active-low); exc_*/ertn_submit commit inputs; csr_eentry/csr_era
// current CSR values; submit_ready/flush status; csr_* write pulses and data; redir_valid/
// redir_pc/redir_ready fetch redirect handshake.
module wb_exc_ctrl
  import exc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int FLUSH_HOLD = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            exc_submit,
  input  logic [5:0]      exc_ecode,
  input  logic [8:0]      exc_esubcode,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_maddr,
  input  logic            ertn_submit,
  input  logic [XLEN-1:0] csr_eentry,
  input  logic [XLEN-1:0] csr_era,
  output logic            submit_ready,
  output logic            flush,
  output logic            csr_exc_we,
  output logic            csr_ertn_we,
  output logic [XLEN-1:0] csr_era_wdata,
  output logic [5:0]      csr_ecode_wdata,
  output logic [8:0]      csr_esub_wdata,
  output logic            csr_badv_we,
  output logic [XLEN-1:0] csr_badv_wdata,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_pc,
  input  logic            redir_ready
);

  localparam logic [3:0] HOLD_INIT = 4'(FLUSH_HOLD);

  state_t     state;
  kind_t      kind_q;
  logic [3:0] hold_cnt;
  logic       accept;

  assign accept = submit_ready && (exc_submit || ertn_submit);

  // Flush must cover the accept cycle itself so nothing younger commits behind the trap.
  assign flush = accept || (state != IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= IDLE;
      kind_q          <= EXC;
      hold_cnt        <= '0;
      submit_ready    <= 1'b1;
      csr_exc_we      <= 1'b0;
      csr_ertn_we     <= 1'b0;
      csr_badv_we     <= 1'b0;
      csr_era_wdata   <= '0;
      csr_ecode_wdata <= '0;
      csr_esub_wdata  <= '0;
      csr_badv_wdata  <= '0;
      redir_valid     <= 1'b0;
      redir_pc        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Exception wins over a same-cycle ertn.
            kind_q          <= exc_submit ? EXC : ERTN;
            csr_era_wdata   <= exc_pc;
            csr_ecode_wdata <= exc_ecode;
            csr_esub_wdata  <= exc_esubcode;
            csr_badv_wdata  <= (exc_ecode == ECODE_ADEF) ? exc_pc : exc_maddr;
            csr_exc_we      <= exc_submit;
            csr_ertn_we     <= !exc_submit;
            csr_badv_we     <= exc_submit && ecode_sets_badv(exc_ecode);
            submit_ready    <= 1'b0;
            state           <= COMMIT;
          end
        end
        COMMIT: begin
          csr_exc_we  <= 1'b0;
          csr_ertn_we <= 1'b0;
          csr_badv_we <= 1'b0;
          // ERA is read here, before any write it could see; ertn never writes ERA.
          redir_pc    <= (kind_q == EXC) ? csr_eentry : csr_era;
          redir_valid <= 1'b1;
          state       <= REDIR;
        end
        REDIR: begin
          if (redir_ready) begin
            redir_valid <= 1'b0;
            if (FLUSH_HOLD == 0) begin
              submit_ready <= 1'b1;
              state        <= IDLE;
            end else begin
              hold_cnt <= HOLD_INIT;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          hold_cnt <= hold_cnt - 4'd1;
          if (hold_cnt == 4'd1) begin
            submit_ready <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          submit_ready <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_exc_ctrl.sv
// Scoreboard bench for wb_exc_ctrl: driver pushes expected CSR pulses and redirects,
// an independent negedge monitor pops and compares them and checks flush/submit_ready windows.
module tb_wb_exc_ctrl;
  import exc_pkg::*;

  localparam int XLEN = 32;
  localparam int FH   = 2;

  logic            clk;
  logic            resetn;
  logic            exc_submit;
  logic [5:0]      exc_ecode;
  logic [8:0]      exc_esubcode;
  logic [XLEN-1:0] exc_pc;
  logic [XLEN-1:0] exc_maddr;
  logic            ertn_submit;
  logic [XLEN-1:0] csr_eentry;
  logic [XLEN-1:0] csr_era;
  logic            submit_ready;
  logic            flush;
  logic            csr_exc_we;
  logic            csr_ertn_we;
  logic [XLEN-1:0] csr_era_wdata;
  logic [5:0]      csr_ecode_wdata;
  logic [8:0]      csr_esub_wdata;
  logic            csr_badv_we;
  logic [XLEN-1:0] csr_badv_wdata;
  logic            redir_valid;
  logic [XLEN-1:0] redir_pc;
  logic            redir_ready;

  wb_exc_ctrl #(.XLEN(XLEN), .FLUSH_HOLD(FH)) dut (
    .clk(clk), .resetn(resetn),
    .exc_submit(exc_submit), .exc_ecode(exc_ecode), .exc_esubcode(exc_esubcode),
    .exc_pc(exc_pc), .exc_maddr(exc_maddr), .ertn_submit(ertn_submit),
    .csr_eentry(csr_eentry), .csr_era(csr_era),
    .submit_ready(submit_ready), .flush(flush),
    .csr_exc_we(csr_exc_we), .csr_ertn_we(csr_ertn_we),
    .csr_era_wdata(csr_era_wdata), .csr_ecode_wdata(csr_ecode_wdata),
    .csr_esub_wdata(csr_esub_wdata), .csr_badv_we(csr_badv_we),
    .csr_badv_wdata(csr_badv_wdata), .redir_valid(redir_valid),
    .redir_pc(redir_pc), .redir_ready(redir_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              cyc;
    logic            is_exc;
    logic [5:0]      ecode;
    logic [8:0]      esub;
    logic [XLEN-1:0] pc;
    logic            badv_we;
    logic [XLEN-1:0] badv;
  } commit_t;

  typedef struct {
    int              first;
    int              hs;
    logic [XLEN-1:0] pc;
  } redir_t;

  commit_t cq[$];
  redir_t  rq[$];
  int checks    = 0;
  int failures  = 0;
  int exp_start = 1;
  int exp_end   = 0;
  bit mon_en    = 0;
  logic [5:0] codes [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: flush covers accept..end of hold; busy (not ready) from the cycle after accept.
  always @(negedge clk) begin : monitor
    commit_t e;
    if (mon_en) begin
      chk("flush", flush, (cyc >= exp_start) && (cyc <= exp_end));
      chk("submit_ready", submit_ready, !((cyc > exp_start) && (cyc <= exp_end)));
      if (csr_exc_we || csr_ertn_we) begin
        if (cq.size() == 0) chk("unexpected_csr_pulse", 1, 0);
        else begin
          e = cq.pop_front();
          chk("pulse_cycle", cyc, e.cyc);
          chk("csr_exc_we", csr_exc_we, e.is_exc);
          chk("csr_ertn_we", csr_ertn_we, !e.is_exc);
          chk("csr_badv_we", csr_badv_we, e.badv_we);
          if (e.is_exc) begin
            chk("csr_era_wdata", csr_era_wdata, e.pc);
            chk("csr_ecode_wdata", csr_ecode_wdata, e.ecode);
            chk("csr_esub_wdata", csr_esub_wdata, e.esub);
            if (e.badv_we) chk("csr_badv_wdata", csr_badv_wdata, e.badv);
          end
        end
      end else begin
        if (csr_badv_we) chk("stray_badv_we", csr_badv_we, 0);
        if (cq.size() != 0 && cq[0].cyc < cyc) begin
          chk("missing_csr_pulse", cyc, cq[0].cyc);
          void'(cq.pop_front());
        end
      end
      if (redir_valid) begin
        if (rq.size() == 0) chk("unexpected_redir", 1, 0);
        else begin
          chk("redir_pc", redir_pc, rq[0].pc);
          if (cyc < rq[0].first) chk("redir_early", cyc, rq[0].first);
          if (redir_ready) begin
            chk("handshake_cycle", cyc, rq[0].hs);
            void'(rq.pop_front());
          end
        end
      end else if (rq.size() != 0 && rq[0].first <= cyc) begin
        chk("missing_redir", cyc, rq[0].first);
        void'(rq.pop_front());
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_submit_ready"}, submit_ready, 1);
    chk({tag, "_flush"}, flush, 0);
    chk({tag, "_csr_exc_we"}, csr_exc_we, 0);
    chk({tag, "_csr_ertn_we"}, csr_ertn_we, 0);
    chk({tag, "_csr_badv_we"}, csr_badv_we, 0);
    chk({tag, "_redir_valid"}, redir_valid, 0);
    chk({tag, "_redir_pc"}, redir_pc, 0);
    chk({tag, "_era_wdata"}, csr_era_wdata, 0);
    chk({tag, "_ecode_wdata"}, csr_ecode_wdata, 0);
    chk({tag, "_esub_wdata"}, csr_esub_wdata, 0);
    chk({tag, "_badv_wdata"}, csr_badv_wdata, 0);
  endtask

  task automatic scramble();
    exc_ecode    = 6'($urandom);
    exc_esubcode = 9'($urandom);
    exc_pc       = $urandom;
    exc_maddr    = $urandom;
  endtask

  // Entered and left just after a rising edge with the DUT idle.
  task automatic run_txn(input bit ex, input bit er, input logic [5:0] ecode,
                         input logic [8:0] esub, input logic [XLEN-1:0] pc,
                         input logic [XLEN-1:0] maddr, input logic [XLEN-1:0] eentry,
                         input logic [XLEN-1:0] era, input int d, input bit dup,
                         input bit rst_mid);
    commit_t c;
    redir_t  r;
    int n = cyc;
    exc_submit   = ex;
    ertn_submit  = er;
    exc_ecode    = ecode;
    exc_esubcode = esub;
    exc_pc       = pc;
    exc_maddr    = maddr;
    csr_eentry   = $urandom;
    csr_era      = $urandom;
    exp_start    = n;
    exp_end      = rst_mid ? n + 2 + d : n + 2 + d + FH;
    c.cyc     = n + 1;
    c.is_exc  = ex;
    c.ecode   = ecode;
    c.esub    = esub;
    c.pc      = pc;
    c.badv_we = ex && (ecode == ECODE_ADEF || ecode == ECODE_ALE);
    c.badv    = (ecode == ECODE_ADEF) ? pc : maddr;
    cq.push_back(c);
    @(posedge clk) #1;
    // COMMIT cycle: the target is whatever EENTRY/ERA hold now.
    exc_submit  = dup;
    ertn_submit = 1'b0;
    scramble();
    csr_eentry  = eentry;
    csr_era     = era;
    r.first = n + 2;
    r.hs    = rst_mid ? -1 : n + 2 + d;
    r.pc    = ex ? eentry : era;
    rq.push_back(r);
    @(posedge clk) #1;
    exc_submit = 1'b0;
    csr_eentry = $urandom;
    csr_era    = $urandom;
    repeat (d) begin
      scramble();
      @(posedge clk) #1;
    end
    if (rst_mid) begin
      resetn = 1'b0;
      @(posedge clk) #1;
      resetn = 1'b1;
      rq.delete();
      @(negedge clk);
      check_reset_outputs("mid_reset");
      @(posedge clk) #1;
    end else begin
      redir_ready = 1'b1;
      @(posedge clk) #1;
      redir_ready = 1'b0;
      repeat (FH) @(posedge clk) #1;
    end
  endtask

  initial begin
    codes[0] = ECODE_INT;  codes[1] = ECODE_ADEF; codes[2] = ECODE_ALE;
    codes[3] = ECODE_SYS;  codes[4] = ECODE_BRK;  codes[5] = ECODE_INE;
    resetn = 1'b0; exc_submit = 1'b0; ertn_submit = 1'b0; redir_ready = 1'b0;
    exc_ecode = '0; exc_esubcode = '0; exc_pc = '0; exc_maddr = '0;
    csr_eentry = '0; csr_era = '0;
    @(posedge clk) #1;
    mon_en = 1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk) #1;
    resetn = 1'b1;
    @(posedge clk) #1;

    // Directed cases.
    run_txn(1, 0, ECODE_SYS, 9'h0, 32'h1c000010, 32'h0, 32'h1c008000, 32'h0, 0, 0, 0);
    run_txn(1, 0, ECODE_ALE, 9'h0, 32'h1c000020, 32'h00000803, 32'h1c008000, 32'h0, 1, 0, 0);
    run_txn(1, 0, ECODE_ADEF, 9'h0, 32'h1c000031, 32'h12345678, 32'h1c008000, 32'h0, 0, 0, 0);
    run_txn(0, 1, 6'h0, 9'h0, 32'h0, 32'h0, 32'h1c008000, 32'h1c000044, 3, 0, 0);
    run_txn(1, 1, ECODE_BRK, 9'h1, 32'h1c000050, 32'h0, 32'h1c00a000, 32'h1c000044, 0, 0, 0);
    run_txn(1, 0, ECODE_INE, 9'h2, 32'h1c000060, 32'h0, 32'h1c00b000, 32'h0, 1, 0, 1);
    run_txn(1, 0, ECODE_SYS, 9'h0, 32'h1c000070, 32'h0, 32'h1c00c000, 32'h0, 0, 1, 0);
    run_txn(0, 1, 6'h0, 9'h0, 32'h1c000080, 32'h0, 32'h0, 32'h1c000090, 0, 0, 0);

    // Randomized commits with idle gaps.
    for (int i = 0; i < 40; i++) begin
      int sel = $urandom_range(0, 9);
      bit ex = (sel < 7) || (sel == 9);
      bit er = (sel >= 7);
      run_txn(ex, er, codes[$urandom_range(0, 5)], 9'($urandom), $urandom, $urandom,
              $urandom, $urandom, $urandom_range(0, 3), ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 9) == 0));
      repeat ($urandom_range(0, 2)) begin
        scramble();
        @(posedge clk) #1;
      end
    end

    repeat (4) @(posedge clk) #1;
    chk("leftover_csr_pulses", cq.size(), 0);
    chk("leftover_redirects", rq.size(), 0);
    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
